// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - ARM pipeline instruction fetch stage with IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    logic [31:0] pc_plus4_f;
    logic [31:0] pc_plus8_f;
    logic [31:0] pc_next_f;
    logic        redirect_f;

    // Next-PC selection: an execute-stage branch is older than nothing in WB
    // that could still be squashed, so it wins; targets are forced word-aligned.
    always_comb begin
        pc_plus4_f = PCF + 32'd4;
        pc_plus8_f = PCF + 32'd8;
        redirect_f = BranchTakenE | PCSrcW;
        if (BranchTakenE) begin
            pc_next_f = {ALUResultE[31:2], 2'b00};
        end else if (PCSrcW) begin
            pc_next_f = {ResultW[31:2], 2'b00};
        end else begin
            pc_next_f = pc_plus4_f;
        end
    end

    // PC register: a redirect must not be lost to a fetch stall, so it overrides StallF.
    always_ff @(posedge clk) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (!StallF || redirect_f) begin
            PCF <= pc_next_f;
        end
    end

    // IF/ID register: flush beats stall so a squashed slot never survives a hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= NOP_INSTR;
            PCPlus8D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCPlus8D <= pc_plus8_f;
            ValidD   <= 1'b1;
        end
    end

endmodule
